// File: rtl/rcv_cu.sv
// UART receive control unit: pairs LSB/MSB bytes into 16-bit FIR samples
// with valid/ready handoff, timeout and framing-error discard, drop counting.
module rcv_cu #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RxD_data_ready,
    input  logic [7:0]            RxD_data,
    input  logic                  RxD_frame_err,
    input  logic                  FIR_ready,
    output logic [15:0]           FIR_sample,
    output logic                  FIR_sample_valid,
    output logic                  timeout_pulse,
    output logic                  ferr_pulse,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MSB,
        PRESENT
    } state_t;

    state_t                  state_q, state_nx;
    logic [7:0]              lsb_q, lsb_nx;
    logic [TW-1:0]           timer_q, timer_nx;
    logic [15:0]             sample_q, sample_nx;
    logic                    tpulse_q, tpulse_nx;
    logic                    fpulse_q, fpulse_nx;
    logic                    ovr_q, ovr_nx;
    logic [DROP_CNT_W-1:0]   drop_q, drop_nx;

    logic good, bad, hs;

    assign good = RxD_data_ready & ~RxD_frame_err;
    assign bad  = RxD_data_ready & RxD_frame_err;
    assign hs   = (state_q == PRESENT) & FIR_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lsb_q    <= '0;
            timer_q  <= '0;
            sample_q <= '0;
            tpulse_q <= 1'b0;
            fpulse_q <= 1'b0;
            ovr_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_nx;
            lsb_q    <= lsb_nx;
            timer_q  <= timer_nx;
            sample_q <= sample_nx;
            tpulse_q <= tpulse_nx;
            fpulse_q <= fpulse_nx;
            ovr_q    <= ovr_nx;
            drop_q   <= drop_nx;
        end
    end

    always_comb begin
        state_nx  = state_q;
        lsb_nx    = lsb_q;
        timer_nx  = timer_q;
        sample_nx = sample_q;
        tpulse_nx = 1'b0;
        fpulse_nx = 1'b0;
        ovr_nx    = ovr_q;
        drop_nx   = drop_q;
        unique case (state_q)
            IDLE: begin
                if (good) begin
                    lsb_nx   = RxD_data;
                    timer_nx = '0;
                    state_nx = WAIT_MSB;
                end else if (bad) begin
                    fpulse_nx = 1'b1;
                end
            end
            WAIT_MSB: begin
                // A byte in the expiry cycle takes priority over the timeout
                if (good) begin
                    sample_nx = {RxD_data, lsb_q};
                    state_nx  = PRESENT;
                end else if (bad) begin
                    lsb_nx    = '0;
                    fpulse_nx = 1'b1;
                    state_nx  = IDLE;
                end else if (timer_q == T_LAST) begin
                    lsb_nx    = '0;
                    timer_nx  = '0;
                    tpulse_nx = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    timer_nx = timer_q + 1'b1;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (good) begin
                        lsb_nx   = RxD_data;
                        timer_nx = '0;
                        state_nx = WAIT_MSB;
                    end else begin
                        fpulse_nx = bad;
                        state_nx  = IDLE;
                    end
                end else if (RxD_data_ready) begin
                    ovr_nx = 1'b1;
                    if (drop_q != '1)
                        drop_nx = drop_q + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign FIR_sample       = sample_q;
    assign FIR_sample_valid = (state_q == PRESENT);
    assign timeout_pulse    = tpulse_q;
    assign ferr_pulse       = fpulse_q;
    assign overrun          = ovr_q;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_rcv_cu.sv
// Directed-vector bench for rcv_cu; a second instance with a 2-bit
// drop counter shares the stimulus to exercise saturation.
module tb_rcv_cu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RxD_data_ready = 1'b0;
    logic [7:0]  RxD_data = 8'h00;
    logic        RxD_frame_err = 1'b0;
    logic        FIR_ready = 1'b0;

    logic [15:0] sample, sample2;
    logic        valid, valid2;
    logic        tpulse, tpulse2;
    logic        fpulse, fpulse2;
    logic        ovr, ovr2;
    logic [7:0]  dcnt;
    logic [1:0]  dcnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rcv_cu #(.TIMEOUT_CYCLES(16), .DROP_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
        .RxD_frame_err(RxD_frame_err), .FIR_ready(FIR_ready),
        .FIR_sample(sample), .FIR_sample_valid(valid),
        .timeout_pulse(tpulse), .ferr_pulse(fpulse),
        .overrun(ovr), .drop_cnt(dcnt)
    );

    rcv_cu #(.TIMEOUT_CYCLES(16), .DROP_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .RxD_data_ready(RxD_data_ready), .RxD_data(RxD_data),
        .RxD_frame_err(RxD_frame_err), .FIR_ready(FIR_ready),
        .FIR_sample(sample2), .FIR_sample_valid(valid2),
        .timeout_pulse(tpulse2), .ferr_pulse(fpulse2),
        .overrun(ovr2), .drop_cnt(dcnt2)
    );

    // All stimulus changes and samples happen on falling edges.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b, input logic e);
        RxD_data_ready = 1'b1;
        RxD_data = b;
        RxD_frame_err = e;
        @(negedge clk);
        RxD_data_ready = 1'b0;
        RxD_frame_err = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++;
        if ({sample, valid, tpulse, fpulse, ovr, dcnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset: got s=%h v=%b t=%b f=%b o=%b d=%0d, want all 0",
                     sample, valid, tpulse, fpulse, ovr, dcnt);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        FIR_ready = 1'b1;
        put(8'h34, 1'b0);
        checks++;
        if (valid !== 1'b0) begin
            errors++; $display("FAIL basic_lsb_valid: got %b want 0", valid);
        end
        put(8'h12, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'h1234) begin
            errors++; $display("FAIL basic_sample: got v=%b s=%h want v=1 s=1234", valid, sample);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0 || sample !== 16'h1234) begin
            errors++; $display("FAIL basic_drop_valid: got v=%b s=%h want v=0 s=1234", valid, sample);
        end
    endtask

    task automatic test_timeout;
        FIR_ready = 1'b1;
        put(8'hAA, 1'b0);
        tick(15);
        checks++;
        if (tpulse !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got %b want 0", tpulse);
        end
        tick(1);
        checks++;
        if (tpulse !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse: got t=%b v=%b want t=1 v=0", tpulse, valid);
        end
        tick(1);
        checks++;
        if (tpulse !== 1'b0) begin
            errors++; $display("FAIL timeout_one_cycle: got %b want 0", tpulse);
        end
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'h0201) begin
            errors++; $display("FAIL timeout_recover: got v=%b s=%h want v=1 s=0201", valid, sample);
        end
        tick(1);
        put(8'hAA, 1'b0);
        tick(15);
        put(8'h77, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'h77AA || tpulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expiry_byte: got v=%b s=%h t=%b want v=1 s=77aa t=0",
                     valid, sample, tpulse);
        end
        tick(1);
        checks++;
        if (tpulse !== 1'b0) begin
            errors++; $display("FAIL timeout_expiry_nopulse: got %b want 0", tpulse);
        end
    endtask

    task automatic test_ferr;
        FIR_ready = 1'b1;
        put(8'h55, 1'b0);
        put(8'h99, 1'b1);
        checks++;
        if (fpulse !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL ferr_wait: got f=%b v=%b want f=1 v=0", fpulse, valid);
        end
        tick(1);
        checks++;
        if (fpulse !== 1'b0) begin
            errors++; $display("FAIL ferr_one_cycle: got %b want 0", fpulse);
        end
        put(8'h78, 1'b0);
        put(8'h56, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'h5678) begin
            errors++; $display("FAIL ferr_recover: got v=%b s=%h want v=1 s=5678", valid, sample);
        end
        tick(1);
        put(8'h00, 1'b1);
        checks++;
        if (fpulse !== 1'b1 || valid !== 1'b0) begin
            errors++; $display("FAIL ferr_idle: got f=%b v=%b want f=1 v=0", fpulse, valid);
        end
        put(8'h21, 1'b0);
        put(8'h43, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'h4321) begin
            errors++; $display("FAIL ferr_idle_stay: got v=%b s=%h want v=1 s=4321", valid, sample);
        end
        tick(1);
    endtask

    task automatic test_overrun;
        FIR_ready = 1'b0;
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        put(8'hA1, 1'b0);
        put(8'hA2, 1'b0);
        put(8'hA3, 1'b1);
        checks++;
        if (fpulse !== 1'b0) begin
            errors++; $display("FAIL ovr_no_ferr: got %b want 0", fpulse);
        end
        checks++;
        if (valid !== 1'b1 || sample !== 16'h2211 || ovr !== 1'b1 || dcnt !== 8'd3) begin
            errors++;
            $display("FAIL ovr_held: got v=%b s=%h o=%b d=%0d want v=1 s=2211 o=1 d=3",
                     valid, sample, ovr, dcnt);
        end
        checks++;
        if (dcnt2 !== 2'd3) begin
            errors++; $display("FAIL ovr_narrow3: got %0d want 3", dcnt2);
        end
        put(8'hA4, 1'b0);
        put(8'hA5, 1'b0);
        checks++;
        if (dcnt !== 8'd5 || dcnt2 !== 2'd3 || sample !== 16'h2211) begin
            errors++;
            $display("FAIL ovr_saturate: got d=%0d d2=%0d s=%h want d=5 d2=3 s=2211",
                     dcnt, dcnt2, sample);
        end
        FIR_ready = 1'b1;
        tick(1);
        checks++;
        if (valid !== 1'b0 || dcnt !== 8'd5 || ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_handshake: got v=%b d=%0d o=%b want v=0 d=5 o=1", valid, dcnt, ovr);
        end
    endtask

    task automatic test_back_to_back;
        FIR_ready = 1'b0;
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        FIR_ready = 1'b1;
        put(8'h9A, 1'b0);
        checks++;
        if (valid !== 1'b0 || dcnt !== 8'd5) begin
            errors++; $display("FAIL b2b_accept: got v=%b d=%0d want v=0 d=5", valid, dcnt);
        end
        put(8'hBC, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'hBC9A || dcnt !== 8'd5) begin
            errors++;
            $display("FAIL b2b_next: got v=%b s=%h d=%0d want v=1 s=bc9a d=5", valid, sample, dcnt);
        end
        tick(1);
    endtask

    task automatic test_mid_reset;
        int seen;
        FIR_ready = 1'b1;
        put(8'h10, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({sample, valid, tpulse, fpulse, ovr, dcnt} !== 28'h0 || dcnt2 !== 2'd0) begin
            errors++;
            $display("FAIL rst_wait: got s=%h v=%b t=%b f=%b o=%b d=%0d, want all 0",
                     sample, valid, tpulse, fpulse, ovr, dcnt);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tpulse !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_no_timeout: got %0d pulses want 0", seen);
        end
        FIR_ready = 1'b0;
        put(8'h66, 1'b0);
        put(8'h77, 1'b0);
        put(8'h88, 1'b0);
        checks++;
        if (valid !== 1'b1 || dcnt !== 8'd1) begin
            errors++; $display("FAIL rst_setup: got v=%b d=%0d want v=1 d=1", valid, dcnt);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if ({sample, valid, tpulse, fpulse, ovr, dcnt} !== 28'h0) begin
            errors++;
            $display("FAIL rst_present: got s=%h v=%b t=%b f=%b o=%b d=%0d, want all 0",
                     sample, valid, tpulse, fpulse, ovr, dcnt);
        end
        FIR_ready = 1'b1;
        put(8'hEF, 1'b0);
        put(8'hBE, 1'b0);
        checks++;
        if (valid !== 1'b1 || sample !== 16'hBEEF) begin
            errors++; $display("FAIL rst_recover: got v=%b s=%h want v=1 s=beef", valid, sample);
        end
        tick(1);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_basic();
        test_timeout();
        test_ferr();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
